// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter slice.
package shift_arbiter_pkg;

  localparam int DEF_DATA_LEN  = 64;
  localparam int DEF_SHAMT_LEN = 6;
  localparam int DEF_ID_LEN    = 4;
  localparam int WORD_LEN      = 32;

  // Result buffer occupancy; FULL is exactly rsp_valid.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Width-independent control fields of a request. The shamt, data and id
  // fields are parameter-sized and travel as separate signals.
  typedef struct packed {
    logic lr;    // 1 = left, 0 = right
    logic al;    // 1 = arithmetic (right only)
    logic word;  // 1 = 32-bit W operation
  } req_ctl_t;

endpackage

// File: rtl/buck_shift.sv
// Combinational barrel shifter: left logical, right logical or right arithmetic.
module buck_shift #(
  parameter int DATA_LEN  = 64,
  parameter int SHAMT_LEN = 6
) (
  input  logic                 lr_i,
  input  logic                 al_i,
  input  logic [SHAMT_LEN-1:0] shamt_i,
  input  logic [DATA_LEN-1:0]  data_i,
  output logic [DATA_LEN-1:0]  data_o
);

  // Left shifts ignore al, so a left request with al=1 is a plain logical left.
  always_comb begin
    data_o = data_i >> shamt_i;
    if (lr_i) begin
      data_o = data_i << shamt_i;
    end else if (al_i) begin
      data_o = $unsigned($signed(data_i) >>> shamt_i);
    end
  end

endmodule

// File: rtl/shift_arbiter_word_fix.sv
// Pure-combinational RV64 W-op handling around the shared shifter: operand
// and shift-amount preparation before it, sign extension of the result after.
module shift_arbiter_word_fix
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_LEN  = 64,
  parameter int SHAMT_LEN = 6
) (
  input  logic                 word_i,
  input  logic                 lr_i,
  input  logic                 al_i,
  input  logic [SHAMT_LEN-1:0] shamt_i,
  input  logic [DATA_LEN-1:0]  data_i,
  output logic [SHAMT_LEN-1:0] shamt_o,
  output logic [DATA_LEN-1:0]  data_o,
  input  logic [DATA_LEN-1:0]  res_i,
  output logic [DATA_LEN-1:0]  res_o
);

  if (DATA_LEN == 64) begin : g_word
    // W ops: 5-bit shamt, right shifts see only the low word (sign- or
    // zero-extended), and the low word of the result is sign-extended.
    always_comb begin
      shamt_o = shamt_i;
      data_o  = data_i;
      res_o   = res_i;
      if (word_i) begin
        shamt_o = {{(SHAMT_LEN-5){1'b0}}, shamt_i[4:0]};
        if (!lr_i) begin
          data_o = al_i ? {{(DATA_LEN-WORD_LEN){data_i[WORD_LEN-1]}}, data_i[WORD_LEN-1:0]}
                        : {{(DATA_LEN-WORD_LEN){1'b0}}, data_i[WORD_LEN-1:0]};
        end
        res_o = {{(DATA_LEN-WORD_LEN){res_i[WORD_LEN-1]}}, res_i[WORD_LEN-1:0]};
      end
    end
  end else begin : g_no_word
    // Word ops do not exist at other widths: pass everything through.
    always_comb begin
      shamt_o = shamt_i;
      data_o  = data_i;
      res_o   = res_i;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for one shared barrel shifter with a
// one-entry registered result buffer.
//
// Handshake: a transfer happens on a port in every cycle where its valid and
// ready are both high at the rising clock edge. A requester must hold its
// valid and payload until that transfer. reqN_ready never looks at reqN_valid;
// it is derived from the other port's valid, rr_ptr and buffer space, so both
// readies may be high together only when no port could contend -- at most one
// transfer happens per cycle. rsp_* are held stable while rsp_valid & ~rsp_ready.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int SHAMT_LEN = DEF_SHAMT_LEN,
  parameter int ID_LEN    = DEF_ID_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_lr,
  input  logic                 req0_al,
  input  logic                 req0_word,
  input  logic [SHAMT_LEN-1:0] req0_shamt,
  input  logic [DATA_LEN-1:0]  req0_data,
  input  logic [ID_LEN-1:0]    req0_id,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_lr,
  input  logic                 req1_al,
  input  logic                 req1_word,
  input  logic [SHAMT_LEN-1:0] req1_shamt,
  input  logic [DATA_LEN-1:0]  req1_data,
  input  logic [ID_LEN-1:0]    req1_id,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_src,
  output logic [ID_LEN-1:0]    rsp_id,
  output logic [DATA_LEN-1:0]  rsp_data,
  output logic                 dbg_state,
  output logic                 dbg_rr_ptr
);

  buf_state_e          state_q, state_d;
  logic                rr_q, rr_d;
  logic                src_q;
  logic [ID_LEN-1:0]   id_q;
  logic [DATA_LEN-1:0] data_q;

  logic                can_accept;
  logic                acc0, acc1, accept;
  req_ctl_t            ctl;
  logic [SHAMT_LEN-1:0] sel_shamt, fix_shamt;
  logic [DATA_LEN-1:0]  sel_data, fix_data, shift_out, result;
  logic [ID_LEN-1:0]    sel_id;

  // Arbitration: a port may go when the other is idle or rr_ptr points at it.
  // Reset is folded in so both readies drop the moment rst_n falls.
  always_comb begin
    can_accept = rst_n & ~flush & ((state_q == BUF_EMPTY) | rsp_ready);
    req0_ready = can_accept & (~req1_valid | ~rr_q);
    req1_ready = can_accept & (~req0_valid |  rr_q);
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    accept     = acc0 | acc1;
  end

  // Request mux: the accepted port (port 0 when idle) feeds the shifter.
  always_comb begin
    ctl       = '{lr: req0_lr, al: req0_al, word: req0_word};
    sel_shamt = req0_shamt;
    sel_data  = req0_data;
    sel_id    = req0_id;
    if (acc1) begin
      ctl       = '{lr: req1_lr, al: req1_al, word: req1_word};
      sel_shamt = req1_shamt;
      sel_data  = req1_data;
      sel_id    = req1_id;
    end
  end

  shift_arbiter_word_fix #(
    .DATA_LEN  (DATA_LEN),
    .SHAMT_LEN (SHAMT_LEN)
  ) u_word_fix (
    .word_i  (ctl.word),
    .lr_i    (ctl.lr),
    .al_i    (ctl.al),
    .shamt_i (sel_shamt),
    .data_i  (sel_data),
    .shamt_o (fix_shamt),
    .data_o  (fix_data),
    .res_i   (shift_out),
    .res_o   (result)
  );

  buck_shift #(
    .DATA_LEN  (DATA_LEN),
    .SHAMT_LEN (SHAMT_LEN)
  ) u_shift (
    .lr_i    (ctl.lr),
    .al_i    (ctl.al),
    .shamt_i (fix_shamt),
    .data_i  (fix_data),
    .data_o  (shift_out)
  );

  // Buffer next state and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else if (accept) begin
      state_d = BUF_FULL;
      rr_d    = ~acc1;
    end else if ((state_q == BUF_FULL) && rsp_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Result payload is loaded only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= 1'b0;
      id_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      src_q  <= acc1;
      id_q   <= sel_id;
      data_q <= result;
    end
  end

  assign rsp_valid  = (state_q == BUF_FULL);
  assign rsp_src    = src_q;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus a random phase, with a
// scoreboard of expected results fed from accepted requests.
module tb_shift_arbiter;

  logic        clk, rst_n, flush;
  logic        req0_valid, req0_ready, req0_lr, req0_al, req0_word;
  logic [5:0]  req0_shamt;
  logic [63:0] req0_data;
  logic [3:0]  req0_id;
  logic        req1_valid, req1_ready, req1_lr, req1_al, req1_word;
  logic [5:0]  req1_shamt;
  logic [63:0] req1_data;
  logic [3:0]  req1_id;
  logic        rsp_valid, rsp_ready, rsp_src;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        dbg_state, dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic        exp_src_q[$];
  logic [3:0]  exp_id_q[$];
  logic        m_rr;

  shift_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_lr    (req0_lr),
    .req0_al    (req0_al),
    .req0_word  (req0_word),
    .req0_shamt (req0_shamt),
    .req0_data  (req0_data),
    .req0_id    (req0_id),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_lr    (req1_lr),
    .req1_al    (req1_al),
    .req1_word  (req1_word),
    .req1_shamt (req1_shamt),
    .req1_data  (req1_data),
    .req1_id    (req1_id),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_src    (rsp_src),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference shift behaviour, written with 32-bit operations for W ops.
  function automatic logic [63:0] model(input logic lr, input logic al, input logic word,
                                        input logic [5:0] sh, input logic [63:0] d);
    logic [31:0] r32;
    logic [63:0] r;
    logic [31:0] lo;
    lo = d[31:0];
    if (word) begin
      if (lr) r32 = lo << sh[4:0];
      else if (al) r32 = $unsigned($signed(lo) >>> sh[4:0]);
      else r32 = lo >> sh[4:0];
      r = {{32{r32[31]}}, r32};
    end else begin
      if (lr) r = d << sh;
      else if (al) r = $unsigned($signed(d) >>> sh);
      else r = d >> sh;
    end
    return r;
  endfunction

  // Scoreboard: compares each delivered result, discards flushed ones and
  // records the expected result of every accepted request.
  always @(negedge clk) begin
    logic [63:0] e_d;
    logic        e_s;
    logic [3:0]  e_i;
    if (rst_n) begin
      if (rsp_valid && flush) begin
        if (exp_q.size() > 0) begin
          e_d = exp_q.pop_front();
          e_s = exp_src_q.pop_front();
          e_i = exp_id_q.pop_front();
        end
      end else if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h src=%0d id=%h, required no response", rsp_data, rsp_src, rsp_id);
        end else begin
          e_d = exp_q.pop_front();
          e_s = exp_src_q.pop_front();
          e_i = exp_id_q.pop_front();
          if ({rsp_data, rsp_src, rsp_id} !== {e_d, e_s, e_i}) begin
            n_fail++;
            $display("FAIL sb_result: got data=%h src=%0d id=%h, required data=%h src=%0d id=%h",
                     rsp_data, rsp_src, rsp_id, e_d, e_s, e_i);
          end
        end
      end
      n_checks++;
      if (req0_valid && req0_ready && req1_valid && req1_ready) begin
        n_fail++;
        $display("FAIL double_accept: got two accepts in one cycle, required at most one");
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back(model(req0_lr, req0_al, req0_word, req0_shamt, req0_data));
        exp_src_q.push_back(1'b0);
        exp_id_q.push_back(req0_id);
        m_rr = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(model(req1_lr, req1_al, req1_word, req1_shamt, req1_data));
        exp_src_q.push_back(1'b1);
        exp_id_q.push_back(req1_id);
        m_rr = 1'b0;
      end
    end
  end

  // Driver helpers.
  task automatic rand_req0();
    req0_lr = 1'($urandom_range(0, 1)); req0_al = 1'($urandom_range(0, 1));
    req0_word = 1'($urandom_range(0, 1)); req0_shamt = 6'($urandom_range(0, 63));
    req0_data = {$urandom, $urandom}; req0_id = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_req1();
    req1_lr = 1'($urandom_range(0, 1)); req1_al = 1'($urandom_range(0, 1));
    req1_word = 1'($urandom_range(0, 1)); req1_shamt = 6'($urandom_range(0, 63));
    req1_data = {$urandom, $urandom}; req1_id = 4'($urandom_range(0, 15));
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_src_q.delete(); exp_id_q.delete();
    m_rr = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset values.
    #12;
    n_checks++;
    if ({rsp_valid, rsp_src, rsp_id, rsp_data, dbg_rr_ptr} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b src=%b id=%h data=%h rr=%b, required all zero",
               rsp_valid, rsp_src, rsp_id, rsp_data, dbg_rr_ptr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // Reset asserted with a result buffered and both ports requesting.
    @(posedge clk); #1;
    rand_req0(); req0_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rand_req1(); req1_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b ready0=%b ready1=%b, required 0 0 0", rsp_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    #5 rst_n = 1'b1;
    clear_sb();
    @(posedge clk); #3;
    n_checks++;
    if ({dbg_rr_ptr, rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got rr=%b valid=%b, required rr=0 valid=0", dbg_rr_ptr, rsp_valid);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_lr = 1'b1; req0_al = 1'b0; req0_word = 1'b0;
    req0_shamt = 6'd4; req0_data = 64'h1; req0_id = 4'hA; rsp_ready = 1'b1;
    #2;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got ready0=%b, required 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    #2;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_src, rsp_id} !== {1'b1, 64'h10, 1'b0, 4'hA}) begin
      n_fail++;
      $display("FAIL single_result: got valid=%b data=%h src=%b id=%h, required 1 %h 0 a",
               rsp_valid, rsp_data, rsp_src, rsp_id, 64'h10);
    end
  endtask

  task automatic test_alternate();
    logic prev_g, g;
    prev_g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rand_req0(); rand_req1();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      #2;
      g = req1_ready;
      n_checks++;
      if ({req0_ready, req1_ready} !== {~m_rr, m_rr}) begin
        n_fail++;
        $display("FAIL alt_grant: got ready0=%b ready1=%b, required %b %b", req0_ready, req1_ready, ~m_rr, m_rr);
      end
      if (i > 0) begin
        n_checks++;
        if (g === prev_g || rsp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL alt_sequence: got grant=%0d prev=%0d valid=%b, required alternating grant with valid=1",
                   g, prev_g, rsp_valid);
        end
      end
      prev_g = g;
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_word();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_word = 1'b1; req1_lr = 1'b0; req1_al = 1'b1;
    req1_shamt = 6'd36; req1_data = 64'h0000_0000_8000_0000; req1_id = 4'h3; rsp_ready = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0;
    #2;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_src} !== {1'b1, 64'hFFFF_FFFF_F800_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL word_sraw: got valid=%b data=%h src=%b, required 1 ffffffff_f8000000 1", rsp_valid, rsp_data, rsp_src);
    end
    // Word left shift: low word shifted, result sign-extended.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_word = 1'b1; req0_lr = 1'b1; req0_al = 1'b1;
    req0_shamt = 6'd33; req0_data = 64'hFFFF_0000_4000_0001; req0_id = 4'h5;
    @(posedge clk); #1 req0_valid = 1'b0;
    #2;
    n_checks++;
    if (rsp_data !== 64'hFFFF_FFFF_8000_0002) begin
      n_fail++;
      $display("FAIL word_sllw: got data=%h, required ffffffff_80000002", rsp_data);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d0;
    logic [3:0]  i0;
    logic        s0;
    @(posedge clk); #1;
    rand_req0(); rand_req1(); req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    d0 = rsp_data; i0 = rsp_id; s0 = rsp_src;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b001 || {rsp_data, rsp_id, rsp_src} !== {d0, i0, s0}) begin
        n_fail++;
        $display("FAIL stall_hold: got ready0=%b ready1=%b valid=%b data=%h, required 0 0 1 data=%h",
                 req0_ready, req1_ready, rsp_valid, rsp_data, d0);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #2;
    n_checks++;
    if ((req0_ready | req1_ready) !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got ready0=%b ready1=%b, required one high", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    rand_req0(); req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #2;
    n_checks++;
    if ({req0_ready, rsp_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_ready: got ready0=%b valid=%b, required 0 1", req0_ready, rsp_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; req0_valid = 1'b0;
    #2;
    n_checks++;
    if ({rsp_valid, dbg_rr_ptr} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%b rr=%b, required valid=0 rr=1", rsp_valid, dbg_rr_ptr);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!(req0_valid && !req0_ready)) begin rand_req0(); req0_valid = 1'($urandom_range(0, 1)); end
      if (!(req1_valid && !req1_ready)) begin rand_req1(); req1_valid = 1'($urandom_range(0, 1)); end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0; m_rr = 1'b0;
    req0_valid = 1'b0; req0_lr = 1'b0; req0_al = 1'b0; req0_word = 1'b0;
    req0_shamt = '0; req0_data = '0; req0_id = '0;
    req1_valid = 1'b0; req1_lr = 1'b0; req1_al = 1'b0; req1_word = 1'b0;
    req1_shamt = '0; req1_data = '0; req1_id = '0;
    test_reset();
    test_single();
    test_alternate();
    test_word();
    test_backpressure();
    test_flush();
    test_random();
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
